rp_dv_pack: RTL and testbench
=============================

// Module: rp_dv_pack
// PURPOSE
//  Consumer side of the chopped ADC data-valid stream. Accepts DW-bit samples qualified by adc_dv_i
//  at any cadence (full rate, 1-of-2 chopped, irregular), packs consecutive pairs into 2*DW-bit
//  words and delivers them over a valid/ready interface through a 2-entry buffer.
//  Monitors idle gaps between valids; flags overflow and cadence violations.
// PARAMETERS
//  DW     14  sample width
//  GAP_W  8   width of gap counter / gap_max_i
// PORTS
//  adc_clk_i    in   1       ADC clock, single clock domain
//  adc_rstn_i   in   1       reset, synchronous, active low
//  adc_dat_i    in   DW      sample, valid when adc_dv_i=1
//  adc_dv_i     in   1       sample valid (no backpressure; must be accepted)
//  flush_i      in   1       emit any partial pair as a half word
//  gap_max_i    in   GAP_W   max allowed idle cycles between valids; 0 = check off
//  sts_clr_i    in   1       clear sticky flags (and counters, if compiled)
//  pk_dat_o     out  2*DW    packed word {newer, older}
//  pk_half_o    out  1       word holds only lower sample (upper = 0)
//  pk_valid_o   out  1       buffer non-empty
//  pk_ready_i   in   1       consumer accepts head word when pk_valid_o=1
//  ovf_o        out  1       sticky: completed word dropped, buffer full
//  gap_err_o    out  1       sticky: gap between valids exceeded gap_max_i
// BEHAVIOUR
//  - Reset: all outputs 0, FSM EMPTY, buffer empty, gap counter 0, gap check disarmed.
//  - FSM EMPTY/HALF, evaluated each cycle:
//    EMPTY, dv=1, flush=0: latch sample as low half -> HALF.
//    EMPTY, dv=1, flush=1: push {0,dat} with half=1, stay EMPTY.
//    EMPTY, dv=0: flush ignored.
//    HALF,  dv=1: push {dat,low} half=0 -> EMPTY (flush same cycle has no further effect).
//    HALF,  dv=0, flush=1: push {0,low} half=1 -> EMPTY.
//  - Push registered: word visible on pk_valid_o/pk_dat_o the cycle after the completing sample.
//  - Buffer: 2-entry FIFO, head on pk_*_o; pop on pk_valid_o & pk_ready_i.
//    Push when full and no pop same cycle: word dropped, ovf_o<=1, contents unchanged.
//    Push when full with pop same cycle: accepted (no drop). Push+pop when empty not bypassed.
//  - Gap monitor: counter +1 per cycle with dv=0, saturating at 2^GAP_W-1, cleared on dv=1.
//    On dv=1 when armed and gap_max_i!=0 and counter>gap_max_i: gap_err_o<=1.
//    First dv after reset arms the check (not itself checked). Chopped 1-of-2 stream: gap=1.
//  - sts_clr_i clears sticky flags; a set event in the same cycle wins (flag stays 1).
//  - Reset mid-operation discards partial pair and buffer contents; no word emitted.
// CONFIGURATION
//  Macro RP_DV_PACK_CNT_EN:
//   defined: adds ports cnt_smp_o out 32 (accepted samples) and cnt_drop_o out 16 (dropped
//            words), both saturating, reset 0, cleared by sts_clr_i (increment same cycle lost).
//   undefined: ports and logic absent; all other behaviour identical.
// STRUCTURE
//  - Package rp_dv_pkg: typedef enum logic {PK_EMPTY, PK_HALF} pk_state_t; localparam PK_FIFO_D=2.
//  - Sub-module rp_dv_fifo2: 2-entry register FIFO, params W, ports push/pop/full/empty/head.
//  - Top holds FSM, gap monitor, sticky flags, optional counters.
// TESTING
//  1 Chopped stream: dv=1,0,1,0..., samples 1..8, ready=1 -> words {2,1},{4,3},{6,5},{8,7},
//    half=0, gap_err=0 with gap_max=1.
//  2 Backpressure: full-rate dv, 8 samples, ready=0 -> 2 words held {2,1},{4,3}, ovf_o=1 after
//    3rd word; ready=1 drains exactly those two; (cnt_drop_o=2 when RP_DV_PACK_CNT_EN).
//  3 Flush: sample 0x155 in HALF then flush_i=1, dv=0 -> word {0,0x155}, half=1 next cycle;
//    EMPTY+dv+flush with 0x2A -> {0,0x2A} half=1.
//  4 Gap: gap_max=3, dv pulses with 3 then 4 idle cycles -> gap_err_o rises only after second;
//    sts_clr_i coincident with a new violation -> gap_err_o stays 1.
//  5 Reset mid-pair: one sample accepted, adc_rstn_i=0 one cycle -> pk_valid_o=0, flags 0,
//    next two samples form first word, first dv after reset sets no gap_err.

Source files
------------

// File: rtl/rp_dv_pkg.sv
// rp_dv_pkg: shared FSM type and buffer depth for the ADC data-valid packer
package rp_dv_pkg;
  typedef enum logic {PK_EMPTY, PK_HALF} pk_state_t;
  localparam int PK_FIFO_D = 2;
endpackage

// File: rtl/rp_dv_fifo2.sv
// rp_dv_fifo2: two-entry register FIFO, head word always presented on head
module rp_dv_fifo2 import rp_dv_pkg::*; #(
  parameter int W = 8
) (
  input  logic         adc_clk_i,
  input  logic         adc_rstn_i,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  logic [W-1:0] d0, d1;
  logic [1:0] cnt, lvl;
  logic do_pop, do_push;
  assign full  = cnt == 2'(PK_FIFO_D);
  assign empty = cnt == 2'd0;
  assign head  = d0;
  // a pop frees a slot in the same cycle, so a push into a full buffer still lands
  always_comb begin
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    lvl     = cnt - {1'b0, do_pop};
  end
  always_ff @(posedge adc_clk_i) begin
    if (!adc_rstn_i) begin
      cnt <= 2'd0;
      d0  <= '0;
      d1  <= '0;
    end else begin
      cnt <= lvl + {1'b0, do_push};
      d0  <= (do_push && lvl == 2'd0) ? din : do_pop ? d1 : d0;
      d1  <= (do_push && lvl == 2'd1) ? din : d1;
    end
  end
endmodule

// File: rtl/rp_dv_pack.sv
// rp_dv_pack: packs ADC sample pairs into 2*DW words with gap/overflow flags; RP_DV_PACK_CNT_EN adds sample/drop counters
module rp_dv_pack import rp_dv_pkg::*; #(
  parameter int DW    = 14,
  parameter int GAP_W = 8
) (
  input  logic            adc_clk_i,
  input  logic            adc_rstn_i,
  input  logic [DW-1:0]   adc_dat_i,
  input  logic            adc_dv_i,
  input  logic            flush_i,
  input  logic [GAP_W-1:0] gap_max_i,
  input  logic            sts_clr_i,
  output logic [2*DW-1:0] pk_dat_o,
  output logic            pk_half_o,
  output logic            pk_valid_o,
  input  logic            pk_ready_i,
  output logic            ovf_o,
  output logic            gap_err_o
`ifdef RP_DV_PACK_CNT_EN
  ,
  output logic [31:0]     cnt_smp_o,
  output logic [15:0]     cnt_drop_o
`endif
);
  pk_state_t st, st_nxt;
  logic [DW-1:0] low;
  logic [2*DW:0] push_word;
  logic [GAP_W-1:0] gap_cnt;
  logic push, full, empty, pop, drop, armed, gap_evt;
  always_comb begin
    push      = (st == PK_HALF) ? (adc_dv_i | flush_i) : (adc_dv_i & flush_i);
    push_word = (st == PK_HALF) ? {~adc_dv_i, adc_dv_i ? adc_dat_i : DW'(0), low}
                                : {1'b1, DW'(0), adc_dat_i};
    st_nxt    = (st == PK_EMPTY && adc_dv_i && !flush_i) ? PK_HALF : push ? PK_EMPTY : st;
  end
  assign pop        = pk_valid_o & pk_ready_i;
  assign pk_valid_o = ~empty;
  assign drop       = push & full & ~pop;
  assign gap_evt    = adc_dv_i & armed & (|gap_max_i) & (gap_cnt > gap_max_i);
  rp_dv_fifo2 #(.W(2*DW+1)) u_fifo (
    .adc_clk_i (adc_clk_i),
    .adc_rstn_i(adc_rstn_i),
    .push      (push),
    .din       (push_word),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head      ({pk_half_o, pk_dat_o})
  );
  always_ff @(posedge adc_clk_i) begin
    if (!adc_rstn_i) begin
      st        <= PK_EMPTY;
      low       <= '0;
      gap_cnt   <= '0;
      armed     <= 1'b0;
      ovf_o     <= 1'b0;
      gap_err_o <= 1'b0;
    end else begin
      st        <= st_nxt;
      low       <= (st == PK_EMPTY && adc_dv_i) ? adc_dat_i : low;
      gap_cnt   <= adc_dv_i ? '0 : (&gap_cnt) ? gap_cnt : gap_cnt + 1'b1;
      armed     <= armed | adc_dv_i;
      ovf_o     <= drop | (ovf_o & ~sts_clr_i);
      gap_err_o <= gap_evt | (gap_err_o & ~sts_clr_i);
    end
  end
`ifdef RP_DV_PACK_CNT_EN
  always_ff @(posedge adc_clk_i) begin
    if (!adc_rstn_i || sts_clr_i) begin
      cnt_smp_o  <= '0;
      cnt_drop_o <= '0;
    end else begin
      cnt_smp_o  <= (adc_dv_i && !(&cnt_smp_o)) ? cnt_smp_o + 32'd1 : cnt_smp_o;
      cnt_drop_o <= (drop && !(&cnt_drop_o)) ? cnt_drop_o + 16'd1 : cnt_drop_o;
    end
  end
`endif
endmodule

// File: tb/tb_rp_dv_pack.sv
// tb_rp_dv_pack: directed scoreboard bench for the ADC data-valid packer
module tb_rp_dv_pack;
  logic adc_clk_i = 1'b0, adc_rstn_i, adc_dv_i, flush_i, sts_clr_i, pk_ready_i;
  logic [13:0] adc_dat_i;
  logic [7:0] gap_max_i;
  logic [27:0] pk_dat_o;
  logic pk_half_o, pk_valid_o, ovf_o, gap_err_o;
`ifdef RP_DV_PACK_CNT_EN
  logic [31:0] cnt_smp_o;
  logic [15:0] cnt_drop_o;
`endif
  logic [28:0] exp_q[$];
  int n_tests = 0, n_fail = 0;
  always #5 adc_clk_i = ~adc_clk_i;
  rp_dv_pack dut (
    .adc_clk_i (adc_clk_i),
    .adc_rstn_i(adc_rstn_i),
    .adc_dat_i (adc_dat_i),
    .adc_dv_i  (adc_dv_i),
    .flush_i   (flush_i),
    .gap_max_i (gap_max_i),
    .sts_clr_i (sts_clr_i),
    .pk_dat_o  (pk_dat_o),
    .pk_half_o (pk_half_o),
    .pk_valid_o(pk_valid_o),
    .pk_ready_i(pk_ready_i),
    .ovf_o     (ovf_o),
    .gap_err_o (gap_err_o)
`ifdef RP_DV_PACK_CNT_EN
    ,
    .cnt_smp_o (cnt_smp_o),
    .cnt_drop_o(cnt_drop_o)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic want(input logic half, input logic [13:0] hi, input logic [13:0] lo);
    exp_q.push_back({half, hi, lo});
  endtask
  // drives one cycle; a handshake seen at the negedge pops the scoreboard
  task automatic cyc(input logic dv = 1'b0, input logic [13:0] d = 14'd0,
                     input logic fl = 1'b0, input logic clr = 1'b0);
    logic [28:0] w;
    adc_dv_i = dv; adc_dat_i = d; flush_i = fl; sts_clr_i = clr;
    @(negedge adc_clk_i);
    if (pk_valid_o === 1'b1 && pk_ready_i) begin
      w = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      chk("word", {3'b0, pk_half_o, pk_dat_o}, {3'b0, w});
    end
    @(posedge adc_clk_i);
    #1;
  endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask
  initial begin
    adc_rstn_i = 1'b0; pk_ready_i = 1'b0; gap_max_i = 8'd1;
    idle(2);
    chk("rst_valid", pk_valid_o, 0);
    chk("rst_dat", {pk_half_o, pk_dat_o}, 0);
    chk("rst_ovf", ovf_o, 0);
    chk("rst_gap", gap_err_o, 0);
    adc_rstn_i = 1'b1;
    idle(1);
    pk_ready_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      if (i % 2 == 0) want(1'b0, 14'(i), 14'(i - 1));
      cyc(1'b1, 14'(i));
      cyc();
    end
    idle(2);
    chk("chop_gap", gap_err_o, 0);
    chk("chop_ovf", ovf_o, 0);
    chk("chop_q", exp_q.size(), 0);
    gap_max_i = 8'd0;
    pk_ready_i = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 14'(i));
      if (i == 2) chk("bp_valid", pk_valid_o, 1);
      if (i == 5) chk("bp_ovf_pre", ovf_o, 0);
      if (i == 6) chk("bp_ovf_post", ovf_o, 1);
    end
    chk("bp_head", {pk_half_o, pk_dat_o}, {1'b0, 14'd2, 14'd1});
`ifdef RP_DV_PACK_CNT_EN
    chk("bp_cnt_drop", cnt_drop_o, 2);
    chk("bp_cnt_smp", cnt_smp_o, 16);
`endif
    pk_ready_i = 1'b1;
    want(1'b0, 14'd4, 14'd3);
    exp_q.push_front({1'b0, 14'd2, 14'd1});
    idle(4);
    chk("bp_drain_valid", pk_valid_o, 0);
    chk("bp_q", exp_q.size(), 0);
    cyc(1'b0, 14'd0, 1'b0, 1'b1);
    chk("bp_ovf_clr", ovf_o, 0);
`ifdef RP_DV_PACK_CNT_EN
    chk("bp_cnt_clr", cnt_drop_o, 0);
`endif
    cyc(1'b0, 14'd0, 1'b1);
    cyc(1'b1, 14'h155);
    want(1'b1, 14'd0, 14'h155);
    cyc(1'b0, 14'd0, 1'b1);
    chk("fl_half", {pk_half_o, pk_dat_o}, {1'b1, 14'd0, 14'h155});
    idle(1);
    want(1'b1, 14'd0, 14'h2A);
    cyc(1'b1, 14'h2A, 1'b1);
    idle(1);
    cyc(1'b1, 14'h11);
    want(1'b0, 14'h22, 14'h11);
    cyc(1'b1, 14'h22, 1'b1);
    idle(2);
    chk("fl_q", exp_q.size(), 0);
    chk("fl_valid", pk_valid_o, 0);
    cyc(1'b1, 14'd1);
    gap_max_i = 8'd3;
    idle(3);
    want(1'b0, 14'd2, 14'd1);
    cyc(1'b1, 14'd2);
    chk("gap_ok", gap_err_o, 0);
    idle(4);
    cyc(1'b1, 14'd3);
    chk("gap_err", gap_err_o, 1);
    cyc(1'b0, 14'd0, 1'b0, 1'b1);
    chk("gap_clr", gap_err_o, 0);
    idle(3);
    want(1'b0, 14'd4, 14'd3);
    cyc(1'b1, 14'd4, 1'b0, 1'b1);
    chk("gap_clr_vs_set", gap_err_o, 1);
    idle(2);
    chk("gap_q", exp_q.size(), 0);
    cyc(1'b1, 14'h7);
    adc_rstn_i = 1'b0;
    cyc();
    adc_rstn_i = 1'b1;
    chk("rr_valid", pk_valid_o, 0);
    chk("rr_gap", gap_err_o, 0);
    chk("rr_ovf", ovf_o, 0);
    idle(5);
    want(1'b0, 14'hB, 14'hA);
    cyc(1'b1, 14'hA);
    chk("rr_first_dv", gap_err_o, 0);
    cyc(1'b1, 14'hB);
    chk("rr_word", {pk_half_o, pk_dat_o}, {1'b0, 14'hB, 14'hA});
    idle(2);
    chk("rr_q", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
